// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, state type and helpers for the wishbone interconnect
package wb_pkg;

   localparam int TIMEOUT_DEFAULT = 255;
   localparam int NUM_SLAVES      = 4;

   localparam logic [1:0] SLV_RAM  = 2'd0;
   localparam logic [1:0] SLV_GPIO = 2'd1;
   localparam logic [1:0] SLV_SPI  = 2'd2;
   localparam logic [1:0] SLV_UART = 2'd3;

   // RAM occupies the bottom 256 KiB; peripherals each own one 256-byte page
   localparam logic [31:0] RAM_MASK    = 32'hFFFC_0000;
   localparam logic [31:0] RAM_MATCH   = 32'h0000_0000;
   localparam logic [31:0] PERIPH_MASK = 32'hFFFF_FF00;
   localparam logic [31:0] GPIO_MATCH  = 32'h0007_0F00;
   localparam logic [31:0] SPI_MATCH   = 32'h0007_F100;
   localparam logic [31:0] UART_MATCH  = 32'h0007_F200;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   // decoder selects are disjoint, so the highest set bit is the only set bit
   function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (oh[i]) idx = i[1:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - address to one-hot slave select decoder
module wb_addr_decode
   import wb_pkg::*;
(
   input  logic [31:0] adr,
   output logic [3:0]  sel,
   output logic        unmapped
);

   // compare masked address against each region's base
   always_comb begin
      sel           = 4'b0000;
      sel[SLV_RAM]  = ((adr & RAM_MASK)    == RAM_MATCH);
      sel[SLV_GPIO] = ((adr & PERIPH_MASK) == GPIO_MATCH);
      sel[SLV_SPI]  = ((adr & PERIPH_MASK) == SPI_MATCH);
      sel[SLV_UART] = ((adr & PERIPH_MASK) == UART_MATCH);
      unmapped      = ~|sel;
   end

endmodule

// File: rtl/wb_intercon.sv
// rtl/wb_intercon.sv - two-master, four-slave wishbone interconnect with round-robin arbitration and bus timeout
module wb_intercon
   import wb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         m0_cyc_i,
   input  logic         m0_stb_i,
   input  logic         m0_we_i,
   input  logic [31:0]  m0_adr_i,
   input  logic [31:0]  m0_dat_i,
   output logic [31:0]  m0_dat_o,
   output logic         m0_ack_o,
   output logic         m0_err_o,
   input  logic         m1_cyc_i,
   input  logic         m1_stb_i,
   input  logic         m1_we_i,
   input  logic [31:0]  m1_adr_i,
   input  logic [31:0]  m1_dat_i,
   output logic [31:0]  m1_dat_o,
   output logic         m1_ack_o,
   output logic         m1_err_o,
   output logic [31:0]  s_adr_o,
   output logic [31:0]  s_dat_o,
   output logic         s_we_o,
   output logic [3:0]   s_cyc_o,
   output logic [3:0]   s_stb_o,
   input  logic [127:0] s_dat_i,
   input  logic [3:0]   s_ack_i
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t        state, state_nxt;
   logic          gnt, gnt_nxt;
   logic          last_gnt, last_gnt_nxt;
   logic [1:0]    slv, slv_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   logic          req0, req1, win;
   logic [31:0]   win_adr;
   logic [3:0]    dec_sel;
   logic          dec_unmapped;
   logic          g_cyc, g_req;
   logic          ack_int, err_int;
   logic [31:0]   dat_int;

   assign req0    = m0_cyc_i & m0_stb_i;
   assign req1    = m1_cyc_i & m1_stb_i;
   assign win     = (req0 & req1) ? ~last_gnt : req1;
   assign win_adr = win ? m1_adr_i : m0_adr_i;
   assign g_cyc   = gnt ? m1_cyc_i : m0_cyc_i;
   assign g_req   = gnt ? req1 : req0;

   wb_addr_decode u_dec (
      .adr      (win_adr),
      .sel      (dec_sel),
      .unmapped (dec_unmapped)
   );

   // state, grant and timeout registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         gnt      <= 1'b0;
         last_gnt <= 1'b1;
         slv      <= 2'd0;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         last_gnt <= last_gnt_nxt;
         slv      <= slv_nxt;
         cnt      <= cnt_nxt;
      end
   end

   // arbitration, slave routing and transaction termination
   always_comb begin
      state_nxt    = state;
      gnt_nxt      = gnt;
      last_gnt_nxt = last_gnt;
      slv_nxt      = slv;
      cnt_nxt      = cnt;
      s_cyc_o      = 4'b0000;
      s_stb_o      = 4'b0000;
      s_adr_o      = gnt ? m1_adr_i : m0_adr_i;
      s_dat_o      = gnt ? m1_dat_i : m0_dat_i;
      s_we_o       = gnt ? m1_we_i  : m0_we_i;
      ack_int      = 1'b0;
      err_int      = 1'b0;
      dat_int      = 32'h0;
      case (state)
         ST_IDLE: begin
            if (req0 | req1) begin
               gnt_nxt   = win;
               slv_nxt   = onehot_to_idx(dec_sel);
               cnt_nxt   = '0;
               state_nxt = dec_unmapped ? ST_ERR : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!g_cyc) begin
               state_nxt = ST_IDLE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               err_int   = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               s_cyc_o[slv] = g_req;
               s_stb_o[slv] = g_req;
               dat_int      = s_dat_i[{slv, 5'd0} +: 32];
               if (s_ack_i[slv]) begin
                  ack_int      = 1'b1;
                  last_gnt_nxt = gnt;
                  state_nxt    = ST_IDLE;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         ST_ERR: begin
            err_int   = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign m0_ack_o = ack_int & ~gnt;
   assign m0_err_o = err_int & ~gnt;
   assign m0_dat_o = gnt ? 32'h0 : dat_int;
   assign m1_ack_o = ack_int & gnt;
   assign m1_err_o = err_int & gnt;
   assign m1_dat_o = gnt ? dat_int : 32'h0;

endmodule
